// File: rtl/rr_grant_ctrl.sv
// Purpose : round-robin grant controller wrapped around a fixed-priority arbiter;
//           registers the winner, holds it until release or MAX_HOLD expiry, rotates start bit.
// Latency : req sampled in IDLE -> ARB on edge 1 -> gnt visible after edge 2; one idle
//           (ARB) cycle between back-to-back grants.
// Backpressure: none; a requester keeps its grant by holding req, and loses it after
//           MAX_HOLD cycles regardless.
//
// Ports (rr_grant_ctrl):
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req[N]          requester lines (also feed the arbiter)
//   arb_gnt[N]      one-hot result from the arbiter
//   arb_valid       arbiter found a requester
//   arb_enable      arbiter enable, high only in ARB
//   arb_priority[N] one-hot start bit for the arbiter search
//   gnt[N]          registered one-hot grant
//   busy            a grant is currently held
//   timeout         one-cycle pulse after a grant was ended by MAX_HOLD
//
// Ports (fixed_prior_arb_give):
//   req[N], enable, prio[N] (one-hot start bit) -> gnt[N] (one-hot), valid

module fixed_prior_arb_give #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic         enable,
   input  logic [N-1:0] prio,
   output logic [N-1:0] gnt,
   output logic         valid
);

   // Double the request vector so the search can wrap past the MSB. Subtracting the
   // one-hot start bit clears the lowest set request at or above it; masking with the
   // inverse isolates that bit, and folding the halves maps it back to N bits.
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] dgnt;

   assign dbl  = {req, req};
   assign dgnt = dbl & ~(dbl - {{N{1'b0}}, prio});

   assign gnt   = enable ? (dgnt[N-1:0] | dgnt[2*N-1:N]) : '0;
   assign valid = enable & (|req);

endmodule

module rr_grant_ctrl #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] arb_gnt,
   input  logic         arb_valid,
   output logic         arb_enable,
   output logic [N-1:0] arb_priority,
   output logic [N-1:0] gnt,
   output logic         busy,
   output logic         timeout
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Encoding chosen so HOLD is a single state bit; busy is then a plain flop output.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ARB  = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     prio_q,  prio_d;
   logic [N-1:0]     gnt_q,   gnt_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             timeout_q, timeout_d;

   logic owner_gone;
   logic hold_expired;

   // Owner release takes precedence over expiry, so a drop on the last allowed
   // cycle is a normal release without a timeout pulse.
   assign owner_gone   = ((req & gnt_q) == '0);
   assign hold_expired = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         prio_q    <= {{(N-1){1'b0}}, 1'b1};
         gnt_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      arb_enable = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ARB;
            end
         end

         ARB: begin
            arb_enable = 1'b1;
            if (arb_valid) begin
               gnt_d   = arb_gnt;
               cnt_d   = CNT_ONE;
               state_d = HOLD;
            end else begin
               // Request withdrawn before arbitration; priority is left untouched.
               state_d = IDLE;
            end
         end

         HOLD: begin
            if (owner_gone || hold_expired) begin
               gnt_d     = '0;
               // Next search starts just above the last winner, MSB wrapping to bit 0.
               prio_d    = {gnt_q[N-2:0], gnt_q[N-1]};
               timeout_d = ~owner_gone;
               state_d   = (|req) ? ARB : IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign arb_priority = prio_q;
   assign gnt          = gnt_q;
   assign busy         = state_q[1];
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] arb_gnt;
   logic         arb_valid;
   logic         arb_enable;
   logic [N-1:0] arb_priority;
   logic [N-1:0] gnt;
   logic         busy;
   logic         timeout;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .arb_gnt     (arb_gnt),
      .arb_valid   (arb_valid),
      .arb_enable  (arb_enable),
      .arb_priority(arb_priority),
      .gnt         (gnt),
      .busy        (busy),
      .timeout     (timeout)
   );

   fixed_prior_arb_give #(.N(N)) arb (
      .req   (req),
      .enable(arb_enable),
      .prio  (arb_priority),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = nobody waiting, 1 = deciding a winner this cycle, 2 = someone owns it
   int m_phase = 0;
   int m_owner = -1;
   int m_held  = 0;
   int m_start = 0;
   bit m_tmo   = 0;
   int m_w;

   function automatic int pick(input logic [N-1:0] r, input int s);
      for (int i = 0; i < N; i++) begin
         if (r[(s + i) % N]) return (s + i) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_owner = -1; m_held = 0; m_start = 0; m_tmo = 0;
      end else begin
         m_tmo = 0;
         case (m_phase)
            0: if (req != '0) m_phase = 1;
            1: begin
               m_w = pick(req, m_start);
               if (m_w >= 0) begin
                  m_owner = m_w; m_held = 1; m_phase = 2;
               end else begin
                  m_phase = 0;
               end
            end
            default: begin
               if (!req[m_owner] || m_held == MAX_HOLD) begin
                  m_tmo   = req[m_owner];
                  m_start = (m_owner + 1) % N;
                  m_owner = -1;
                  m_phase = (req != '0) ? 1 : 0;
               end else begin
                  m_held++;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [N-1:0] one;
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_prio;
      one    = 1;
      e_gnt  = (m_owner >= 0) ? (one << m_owner) : '0;
      e_prio = one << m_start;
      check("model_gnt",     32'(gnt),          32'(e_gnt));
      check("model_busy",    32'(busy),         32'(m_owner >= 0));
      check("model_enable",  32'(arb_enable),   32'(m_phase == 1));
      check("model_prio",    32'(arb_priority), 32'(e_prio));
      check("model_timeout", 32'(timeout),      32'(m_tmo));
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] exp;
      rst = 1'b1;
      req = '0;
      cyc(2);
      check("rst_enable",  32'(arb_enable),   32'h0);
      check("rst_prio",    32'(arb_priority), 32'h1);
      check("rst_gnt",     32'(gnt),          32'h0);
      check("rst_busy",    32'(busy),         32'h0);
      check("rst_timeout", 32'(timeout),      32'h0);
      rst = 1'b0;
      cyc(1);

      // Single requester, three grant cycles.
      req = 4'b0100;
      cyc(1);
      check("single_arb_en", 32'(arb_enable), 32'h1);
      check("single_gap",    32'(gnt),        32'h0);
      cyc(1);
      check("single_gnt1", 32'(gnt), 32'h4);
      cyc(1);
      check("single_gnt2", 32'(gnt), 32'h4);
      cyc(1);
      check("single_gnt3", 32'(gnt), 32'h4);
      req = '0;
      cyc(1);
      check("single_drop", 32'(gnt),          32'h0);
      check("single_prio", 32'(arb_priority), 32'h8);
      cyc(2);

      // Timeout: 0011 held constantly.
      do_reset();
      req = 4'b0011;
      cyc(1);
      check("to_gap0", 32'(gnt), 32'h0);
      for (int i = 0; i < MAX_HOLD; i++) begin
         cyc(1);
         check("to_hold", 32'(gnt), 32'h1);
      end
      cyc(1);
      check("to_gnt_off", 32'(gnt),     32'h0);
      check("to_pulse",   32'(timeout), 32'h1);
      cyc(1);
      check("to_next",    32'(gnt),     32'h2);
      check("to_cleared", 32'(timeout), 32'h0);

      // Release coinciding with the last allowed hold cycle.
      cyc(MAX_HOLD - 1);
      check("co_last", 32'(gnt), 32'h2);
      req = '0;
      cyc(1);
      check("co_gnt",     32'(gnt),     32'h0);
      check("co_timeout", 32'(timeout), 32'h0);
      cyc(2);

      // Withdrawn request.
      do_reset();
      req = 4'b0010;
      cyc(1);
      req = '0;
      check("wd_arb", 32'(arb_enable), 32'h1);
      cyc(1);
      check("wd_gnt",  32'(gnt),          32'h0);
      check("wd_idle", 32'(arb_enable),   32'h0);
      check("wd_prio", 32'(arb_priority), 32'h1);
      cyc(2);

      // Fair rotation with single-cycle release pulses.
      do_reset();
      req = 4'b1111;
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % N);
         cyc(1);
         check("rot_gnt", 32'(gnt), 32'(exp));
         cyc(1);
         req = 4'b1111 & ~exp;
         cyc(1);
         check("rot_gap", 32'(gnt), 32'h0);
         req = 4'b1111;
      end
      req = '0;
      cyc(3);

      // Reset during HOLD.
      do_reset();
      req = 4'b0100;
      cyc(2);
      check("rh_pre", 32'(gnt), 32'h4);
      #1 rst = 1'b1;
      #1;
      check("rh_gnt",    32'(gnt),          32'h0);
      check("rh_busy",   32'(busy),         32'h0);
      check("rh_enable", 32'(arb_enable),   32'h0);
      check("rh_prio",   32'(arb_priority), 32'h1);
      cyc(1);
      req = 4'b1111;
      rst = 1'b0;
      cyc(2);
      check("rh_first", 32'(gnt), 32'h1);

      // Randomized traffic; the owner keeps its bit with high probability so that
      // full-length holds and timeouts happen regularly.
      repeat (3000) begin
         r = N'($urandom);
         if ($urandom_range(0, 9) == 0) r = '0;
         if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 7) != 0);
         req = r;
         cyc(1);
      end
      req = '0;
      cyc(4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
